// File: rtl/fmc_i2c_pkg.sv
// Shared types and the constant register-write table for the FMC424 I2C init sequencer.
// Optional response watchdog in the top is enabled with FMC_I2C_TIMEOUT_EN.
package fmc_i2c_pkg;

  typedef struct packed {
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } i2c_wr_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_NEXT     = 3'd3,
    ST_BACKOFF  = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } seq_state_e;

  localparam int INIT_TABLE_LEN = 8;

  // CPLD control/LED writes bracket the clock-chip (0x68) setup writes.
  localparam i2c_wr_t INIT_TABLE [INIT_TABLE_LEN] = '{
    '{7'h3E, 8'h02, 8'h01},
    '{7'h3E, 8'h03, 8'h10},
    '{7'h68, 8'hE6, 8'h10},
    '{7'h68, 8'h06, 8'h00},
    '{7'h68, 8'h1C, 8'h16},
    '{7'h68, 8'h1D, 8'h90},
    '{7'h68, 8'hE6, 8'h00},
    '{7'h3E, 8'h02, 8'h03}
  };

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic i2c_wr_t table_entry(int unsigned idx);
    if (idx < INIT_TABLE_LEN) return INIT_TABLE[idx[2:0]];
    return '0;
  endfunction

  function automatic logic [7:0] entry_byte(i2c_wr_t e, logic [1:0] sel);
    case (sel)
      2'd0:    return {e.dev_addr, 1'b0};
      2'd1:    return e.reg_addr;
      default: return e.data;
    endcase
  endfunction

endpackage

// File: rtl/fmc_i2c_wait_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module fmc_i2c_wait_timer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/fmc_i2c_init_sequencer.sv
// Walks INIT_TABLE issuing START/addr/reg/data/STOP byte commands with NACK retry and back-off.
// Define FMC_I2C_TIMEOUT_EN to treat a missing response after TIMEOUT_CYCLES as a NACK.
module fmc_i2c_init_sequencer
  import fmc_i2c_pkg::*;
#(
  parameter int NUM_CMDS       = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_WAIT     = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                           CLK,
  input  logic                           reset_n,
  input  logic                           go,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [idx_width(NUM_CMDS)-1:0] err_index,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [7:0]                     cmd_byte,
  output logic                           cmd_start,
  output logic                           cmd_stop,
  input  logic                           rsp_valid,
  input  logic                           rsp_nack
);

  localparam int IDX_W     = idx_width(NUM_CMDS);
  localparam int RTY_W     = idx_width(MAX_RETRIES + 1);
  localparam int TIMER_MAX = (RETRY_WAIT > TIMEOUT_CYCLES) ? RETRY_WAIT : TIMEOUT_CYCLES;
  localparam int TIMER_W   = idx_width(TIMER_MAX + 1);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         byte_q, byte_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               enter_issue;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_expired;
  logic               handshake;
  logic               nack_evt;
  i2c_wr_t            issue_entry;

  assign handshake   = cmd_valid && cmd_ready;
  assign issue_entry = table_entry(32'(idx_d));

`ifdef FMC_I2C_TIMEOUT_EN
  assign nack_evt = rsp_valid ? rsp_nack : timer_expired;
`else
  assign nack_evt = rsp_valid && rsp_nack;
`endif

  fmc_i2c_wait_timer #(.WIDTH(TIMER_W)) u_timer (
    .CLK     (CLK),
    .reset_n (reset_n),
    .load    (timer_load),
    .value   (timer_value),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    retry_d     = retry_q;
    enter_issue = 1'b0;
    timer_load  = 1'b0;
    timer_value = TIMER_W'(RETRY_WAIT);
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (go) begin
          state_d     = ST_ISSUE;
          idx_d       = '0;
          byte_d      = '0;
          retry_d     = '0;
          enter_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (handshake) begin
          state_d = ST_WAIT_RSP;
`ifdef FMC_I2C_TIMEOUT_EN
          timer_load  = 1'b1;
          timer_value = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ST_WAIT_RSP: begin
        if (rsp_valid && !rsp_nack) begin
          if (byte_q != 2'd2) begin
            byte_d      = byte_q + 2'd1;
            state_d     = ST_ISSUE;
            enter_issue = 1'b1;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (nack_evt) begin
          if (retry_q == RTY_W'(MAX_RETRIES)) begin
            state_d = ST_FAIL;
          end else begin
            state_d    = ST_BACKOFF;
            timer_load = 1'b1;
          end
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_W'(NUM_CMDS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d       = idx_q + IDX_W'(1);
          byte_d      = '0;
          retry_d     = '0;
          state_d     = ST_ISSUE;
          enter_issue = 1'b1;
        end
      end
      ST_BACKOFF: begin
        if (timer_expired) begin
          retry_d     = retry_q + RTY_W'(1);
          byte_d      = '0;
          state_d     = ST_ISSUE;
          enter_issue = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte fields are loaded only when a new command is offered, so they hold through backpressure.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      byte_q    <= '0;
      retry_q   <= '0;
      cmd_byte  <= '0;
      cmd_start <= 1'b0;
      cmd_stop  <= 1'b0;
      err_index <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      retry_q <= retry_d;
      if (enter_issue) begin
        cmd_byte  <= entry_byte(issue_entry, byte_d);
        cmd_start <= (byte_d == 2'd0);
        cmd_stop  <= (byte_d == 2'd2);
      end
      if (state_d == ST_FAIL && state_q != ST_FAIL) begin
        err_index <= idx_q;
      end
    end
  end

  assign cmd_valid = (state_q == ST_ISSUE);
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP) ||
                     (state_q == ST_NEXT)  || (state_q == ST_BACKOFF);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_FAIL);

endmodule

// File: tb/tb_fmc_i2c_init_sequencer.sv
// Self-checking bench for fmc_i2c_init_sequencer: a bus responder records handshaken bytes,
// and each test compares them against an expected-byte queue built when go is issued.
module tb_fmc_i2c_init_sequencer;

  localparam int NUM_CMDS       = 8;
  localparam int MAX_RETRIES    = 3;
  localparam int RETRY_WAIT     = 12;
  localparam int TIMEOUT_CYCLES = 16;

  logic       CLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
  logic       busy, done, error;
  logic [2:0] err_index;
  logic       cmd_valid, cmd_start, cmd_stop;
  logic [7:0] cmd_byte;

  int n_checks = 0;
  int n_fail   = 0;

  logic [22:0] tbl [NUM_CMDS];
  logic [9:0]  exp_q [$];
  logic [9:0]  obs_q [$];
  int          gap_q [$];
  logic [8:0]  stall_q [$];

  always #5 CLK = ~CLK;

  fmc_i2c_init_sequencer #(
    .NUM_CMDS       (NUM_CMDS),
    .MAX_RETRIES    (MAX_RETRIES),
    .RETRY_WAIT     (RETRY_WAIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .go        (go),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_index (err_index),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_byte  (cmd_byte),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .rsp_valid (rsp_valid),
    .rsp_nack  (rsp_nack)
  );

  task automatic push_entry(input int e);
    logic [22:0] t;
    t = tbl[e];
    exp_q.push_back({t[22:16], 1'b0, 2'b10});
    exp_q.push_back({t[15:8], 2'b00});
    exp_q.push_back({t[7:0], 2'b01});
  endtask

  task automatic pulse_go();
    @(posedge CLK); #1 go = 1'b1;
    @(posedge CLK); #1 go = 1'b0;
  endtask

  // Byte-master model: one-cycle response after each accepted byte, optional NACKs on a chosen
  // entry's byte0, optional backpressure on a chosen handshake, optional silence (no response).
  task automatic serve(input int nack_entry, input int nack_count, input int stall_at,
                       input int stall_len, input bit no_rsp, input int max_cycles,
                       output bit timed_out);
    int ent, byt, given, gap, stalled;
    bit pending, counting, nack;
    obs_q.delete(); gap_q.delete(); stall_q.delete();
    ent = 0; byt = 0; given = 0; gap = 0; stalled = 0;
    pending = 1'b0; counting = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (counting) begin
        if (cmd_valid) begin
          gap_q.push_back(gap);
          counting = 1'b0;
        end else begin
          gap++;
        end
      end
      if (done || error) begin
        timed_out = 1'b0;
        break;
      end
      if (pending && !no_rsp) begin
        nack      = (ent == nack_entry) && (byt == 0) && (given < nack_count);
        rsp_valid = 1'b1;
        rsp_nack  = nack;
        pending   = 1'b0;
        if (nack) begin
          given++;
          byt = 0;
          counting = 1'b1;
          gap = 0;
        end else begin
          byt++;
          if (byt == 3) begin
            byt = 0;
            ent++;
          end
        end
      end
      cmd_ready = 1'b1;
      if (cmd_valid && stall_at == obs_q.size() && stalled < stall_len) begin
        cmd_ready = 1'b0;
        stall_q.push_back({cmd_valid, cmd_byte});
        stalled++;
      end
      if (cmd_valid && cmd_ready) begin
        obs_q.push_back({cmd_byte, cmd_start, cmd_stop});
        pending = 1'b1;
        if (no_rsp) begin
          counting = 1'b1;
          gap = 0;
        end
      end
      @(posedge CLK); #1;
    end
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({busy, done, error, cmd_valid, cmd_start, cmd_stop, cmd_byte, err_index} !== 17'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: busy=%b done=%b error=%b valid=%b start=%b stop=%b byte=%h idx=%0d, required all 0",
               busy, done, error, cmd_valid, cmd_start, cmd_stop, cmd_byte, err_index);
    end
    @(negedge CLK) reset_n = 1'b1;
  endtask

  task automatic test_nominal();
    bit to;
    logic [9:0] e, o;
    exp_q.delete();
    pulse_go();
    for (int i = 0; i < NUM_CMDS; i++) push_entry(i);
    n_checks++;
    if ({busy, cmd_valid, cmd_byte, cmd_start, cmd_stop} !== {2'b11, 8'h7C, 2'b10}) begin
      n_fail++;
      $display("[TB] FAIL nominal_go_latency: busy=%b valid=%b byte=%h start=%b stop=%b, required 1 1 7c 1 0",
               busy, cmd_valid, cmd_byte, cmd_start, cmd_stop);
    end
    serve(-1, 0, -1, 0, 1'b0, 2000, to);
    n_checks++;
    if (to) begin n_fail++; $display("[TB] FAIL nominal_timeout: run did not finish, required done"); end
    n_checks++;
    if (obs_q.size() != 3 * NUM_CMDS) begin
      n_fail++;
      $display("[TB] FAIL nominal_handshakes: got %0d, required %0d", obs_q.size(), 3 * NUM_CMDS);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL nominal_byte: missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("[TB] FAIL nominal_byte: got byte=%h start=%b stop=%b, required byte=%h start=%b stop=%b",
                   o[9:2], o[1], o[0], e[9:2], e[1], e[0]);
        end
      end
    end
    n_checks++;
    if ({done, error, busy} !== 3'b100) begin
      n_fail++; $display("[TB] FAIL nominal_status: done=%b error=%b busy=%b, required 1 0 0", done, error, busy);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [9:0] e, o;
    exp_q.delete();
    pulse_go();
    for (int i = 0; i < NUM_CMDS; i++) push_entry(i);
    serve(-1, 0, 1, 5, 1'b0, 2000, to);
    n_checks++;
    if (to || stall_q.size() != 5) begin
      n_fail++; $display("[TB] FAIL bp_stall_samples: got %0d timeout=%b, required 5 timeout=0", stall_q.size(), to);
    end
    foreach (stall_q[i]) begin
      n_checks++;
      if (stall_q[i] !== {1'b1, 8'h02}) begin
        n_fail++; $display("[TB] FAIL bp_hold: cycle %0d valid=%b byte=%h, required 1 02", i, stall_q[i][8], stall_q[i][7:0]);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("[TB] FAIL bp_byte: got %h, required %h", o, e);
      end
    end
    n_checks++;
    if (obs_q.size() != 0 || done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL bp_end: extra=%0d done=%b, required 0 1", obs_q.size(), done);
    end
  endtask

  task automatic test_single_nack();
    bit to;
    logic [9:0] e, o;
    exp_q.delete();
    pulse_go();
    exp_q.push_back({8'h7C, 2'b10});
    for (int i = 0; i < NUM_CMDS; i++) push_entry(i);
    serve(0, 1, -1, 0, 1'b0, 2000, to);
    n_checks++;
    if (gap_q.size() != 1 || gap_q[0] != RETRY_WAIT + 1) begin
      n_fail++;
      $display("[TB] FAIL nack_backoff_gap: got %0d gaps first=%0d, required 1 gap of %0d",
               gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1, RETRY_WAIT + 1);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("[TB] FAIL nack_byte: got %h, required %h", o, e);
      end
    end
    n_checks++;
    if (to || obs_q.size() != 0 || {done, error} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL nack_end: timeout=%b extra=%0d done=%b error=%b, required 0 0 1 0",
                         to, obs_q.size(), done, error);
    end
  endtask

  task automatic test_persistent_nack();
    bit to;
    logic [9:0] e, o;
    exp_q.delete();
    pulse_go();
    push_entry(0);
    push_entry(1);
    for (int a = 0; a <= MAX_RETRIES; a++) exp_q.push_back({tbl[2][22:16], 1'b0, 2'b10});
    serve(2, MAX_RETRIES + 1, -1, 0, 1'b0, 2000, to);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 10'h3FF;
      n_checks++;
      if (o !== e) begin
        n_fail++; $display("[TB] FAIL fail_byte: got %h, required %h", o, e);
      end
    end
    n_checks++;
    if (to || obs_q.size() != 0 || {error, done, busy} !== 3'b100 || err_index !== 3'd2) begin
      n_fail++; $display("[TB] FAIL fail_status: timeout=%b extra=%0d error=%b done=%b busy=%b idx=%0d, required 0 0 1 0 0 2",
                         to, obs_q.size(), error, done, busy, err_index);
    end
    n_checks++;
    if (gap_q.size() != MAX_RETRIES) begin
      n_fail++; $display("[TB] FAIL fail_retry_gaps: got %0d, required %0d", gap_q.size(), MAX_RETRIES);
    end
    foreach (gap_q[i]) begin
      n_checks++;
      if (gap_q[i] != RETRY_WAIT + 1) begin
        n_fail++; $display("[TB] FAIL fail_gap: retry %0d got %0d, required %0d", i, gap_q[i], RETRY_WAIT + 1);
      end
    end
    exp_q.delete();
    pulse_go();
    n_checks++;
    if ({error, cmd_valid, cmd_byte, cmd_start} !== {2'b01, 8'h7C, 1'b1}) begin
      n_fail++; $display("[TB] FAIL fail_restart: error=%b valid=%b byte=%h start=%b, required 0 1 7c 1",
                         error, cmd_valid, cmd_byte, cmd_start);
    end
    for (int i = 0; i < NUM_CMDS; i++) push_entry(i);
    serve(-1, 0, -1, 0, 1'b0, 2000, to);
    n_checks++;
    if (to || obs_q.size() != exp_q.size() || done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fail_rerun: timeout=%b got %0d bytes done=%b, required 0 %0d 1",
                         to, obs_q.size(), done, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_run();
    bit to;
    pulse_go();
    cmd_ready = 1'b1;
    @(posedge CLK); #1;
    cmd_ready = 1'b0;
    n_checks++;
    if ({busy, cmd_valid} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL midrst_wait_rsp: busy=%b valid=%b, required 1 0", busy, cmd_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, error, cmd_valid, cmd_start, cmd_stop, cmd_byte, err_index} !== 17'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: busy=%b done=%b error=%b valid=%b start=%b stop=%b byte=%h idx=%0d, required all 0",
               busy, done, error, cmd_valid, cmd_start, cmd_stop, cmd_byte, err_index);
    end
    @(negedge CLK) reset_n = 1'b1;
    exp_q.delete();
    pulse_go();
    for (int i = 0; i < NUM_CMDS; i++) push_entry(i);
    serve(-1, 0, -1, 0, 1'b0, 2000, to);
    n_checks++;
    if (to || obs_q.size() != exp_q.size() || obs_q[0] !== 10'h1F2 || done !== 1'b1) begin
      n_fail++; $display("[TB] FAIL midrst_rerun: timeout=%b bytes=%0d done=%b, required 0 %0d 1",
                         to, obs_q.size(), done, exp_q.size());
    end
  endtask

`ifdef FMC_I2C_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    pulse_go();
    serve(-1, 0, -1, 0, 1'b1, TIMEOUT_CYCLES + RETRY_WAIT + 10, to);
    n_checks++;
    if (gap_q.size() < 1 || gap_q[0] != TIMEOUT_CYCLES + RETRY_WAIT + 1) begin
      n_fail++; $display("[TB] FAIL timeout_gap: got %0d, required %0d",
                         (gap_q.size() > 0) ? gap_q[0] : -1, TIMEOUT_CYCLES + RETRY_WAIT + 1);
    end
    n_checks++;
    if (obs_q.size() < 2 || obs_q[1] !== 10'h1F2) begin
      n_fail++; $display("[TB] FAIL timeout_reissue: got %0d bytes, required reissued 7c with start");
    end
    reset_n = 1'b0;
    @(negedge CLK) reset_n = 1'b1;
  endtask
`endif

  initial begin
    tbl[0] = {7'h3E, 8'h02, 8'h01};
    tbl[1] = {7'h3E, 8'h03, 8'h10};
    tbl[2] = {7'h68, 8'hE6, 8'h10};
    tbl[3] = {7'h68, 8'h06, 8'h00};
    tbl[4] = {7'h68, 8'h1C, 8'h16};
    tbl[5] = {7'h68, 8'h1D, 8'h90};
    tbl[6] = {7'h68, 8'hE6, 8'h00};
    tbl[7] = {7'h3E, 8'h02, 8'h03};
    test_reset();
    test_nominal();
    test_backpressure();
    test_single_nack();
    test_persistent_nack();
    test_reset_mid_run();
`ifdef FMC_I2C_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
